// File: rtl/l2_mem_rsp_pkg.sv
// l2_mem_rsp_pkg: shared FSM state type for the L2 memory-side responder.
package l2_mem_rsp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} rsp_state_e;
endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: DEPTH-entry synchronous request FIFO.
// Ports: clk, rst (async active-low), push/wdata (ignored when full),
//        pop/rdata (rdata shows the head; pop ignored when empty), full, empty.
module mem_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;
    assign full    = cnt_q == (PW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];
    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/l2_mem_responder.sv
// l2_mem_responder: in-order, fixed-latency line read/write responder backing the L2.
// Ports: clk, rst (async active-low); request channel req_valid/req_ready with
//        req_write/req_addr/req_wdata/req_tag; response channel rsp_valid/rsp_ready with
//        rsp_write/rsp_data/rsp_tag (+ rsp_err when MEM_RSP_RANGE_CHK_EN is defined); busy.
// Define MEM_RSP_RANGE_CHK_EN to flag (and suppress) accesses with address bits above the array.
module l2_mem_responder
    import l2_mem_rsp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 512,
    parameter int TAG_W     = 4,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 8,
    parameter int MEM_LINES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [LINE_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
`ifdef MEM_RSP_RANGE_CHK_EN
    output logic              rsp_err,
`endif
    output logic              busy
);
    localparam int OFF_W = $clog2(LINE_W/8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(LATENCY+1);
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } req_entry_t;
    rsp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_entry_t        cur_q, cur_d, in_e, head;
    logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [LINE_W-1:0] mem_q [MEM_LINES];
    logic [IDX_W-1:0]  idx;
    logic              full, empty, pop, oor, mem_we, unused_bits;
    assign in_e = '{write: req_write, addr: req_addr, wdata: req_wdata, tag: req_tag};
    mem_rsp_fifo #(.W($bits(req_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .pop   (pop),
        .wdata (in_e),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    assign idx = cur_q.addr[OFF_W +: IDX_W];
`ifdef MEM_RSP_RANGE_CHK_EN
    assign oor         = |cur_q.addr[ADDR_W-1:OFF_W+IDX_W];
    assign rsp_err     = rsp_err_q;
    assign unused_bits = ^cur_q.addr[OFF_W-1:0];
`else
    assign oor         = 1'b0;
    assign unused_bits = ^{cur_q.addr[OFF_W-1:0], cur_q.addr[ADDR_W-1:OFF_W+IDX_W], rsp_err_q};
`endif
    assign req_ready = !full;
    assign rsp_valid = state_q == RESP;
    assign rsp_write = cur_q.write;
    assign rsp_tag   = cur_q.tag;
    assign rsp_data  = rsp_data_q;
    assign busy      = !empty || state_q != IDLE;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        pop        = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                cur_d   = head;
                cnt_d   = CNT_W'(LATENCY-1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                // Commit point: array write or read capture happens on the WAIT->RESP edge.
                state_d    = RESP;
                mem_we     = cur_q.write && !oor;
                rsp_data_d = (cur_q.write || oor) ? '0 : mem_q[idx];
                rsp_err_d  = oor;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= cur_q.wdata;
    end
endmodule
